// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift, iterative shift-add multiply
// and restoring divide, valid/ready input handshake and registered one-cycle result pulse.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [3:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             div_by_zero,
  output logic             illegal_op
);

  // state  | meaning
  // S_IDLE | ready; single-cycle ops complete on the accept edge
  // S_MUL  | shift-add multiply, one multiplier bit per edge
  // S_DIV  | restoring divide, one quotient bit per edge
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SHL1 = 4'd4;
  localparam logic [3:0] OP_SHR1 = 4'd5;
  localparam logic [3:0] OP_SHL2 = 4'd6;
  localparam logic [3:0] OP_SHR2 = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_XOR = 4'd10;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     div_m_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     result_hi_q;
  logic                 out_valid_q;
  logic                 zero_q;
  logic                 carry_q;
  logic                 dbz_q;
  logic                 ill_q;

  logic [WIDTH-1:0]     sc_res_d;
  logic [WIDTH-1:0]     sc_hi_d;
  logic                 sc_carry_d;
  logic                 sc_dbz_d;
  logic                 sc_ill_d;
  logic [WIDTH:0]       sum_d;
  logic [WIDTH:0]       diff_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH:0]       div_sh_d;
  logic [WIDTH:0]       trial_d;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     quo_d;
  logic                 last_iter_d;

  assign in_ready    = (state_q == S_IDLE);
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign out_valid   = out_valid_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

  // Single-cycle results, including the divide-by-zero shortcut and illegal opcodes.
  always_comb begin
    sum_d      = {1'b0, operand1} + {1'b0, operand2};
    diff_d     = {1'b0, operand1} - {1'b0, operand2};
    sc_res_d   = '0;
    sc_hi_d    = '0;
    sc_carry_d = 1'b0;
    sc_dbz_d   = 1'b0;
    sc_ill_d   = 1'b0;
    case (operation)
      OP_ADD:  begin sc_res_d = sum_d[WIDTH-1:0];  sc_carry_d = sum_d[WIDTH];  end
      OP_SUB:  begin sc_res_d = diff_d[WIDTH-1:0]; sc_carry_d = diff_d[WIDTH]; end
      OP_DIV:  begin sc_res_d = '1; sc_hi_d = operand1; sc_dbz_d = 1'b1; end
      OP_SHL1: sc_res_d = operand1 << 1;
      OP_SHR1: sc_res_d = operand1 >> 1;
      OP_SHL2: sc_res_d = operand2 << 1;
      OP_SHR2: sc_res_d = operand2 >> 1;
      OP_AND:  sc_res_d = operand1 & operand2;
      OP_OR:   sc_res_d = operand1 | operand2;
      OP_XOR:  sc_res_d = operand1 ^ operand2;
      OP_MUL:  sc_res_d = '0;
      default: sc_ill_d = 1'b1;
    endcase
  end

  always_comb begin
    acc_d       = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    div_sh_d    = {rem_q, quo_q[WIDTH-1]};
    trial_d     = div_sh_d - {1'b0, div_m_q};
    // Trial MSB set means the shifted remainder was smaller than the divisor.
    rem_d       = trial_d[WIDTH] ? div_sh_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    quo_d       = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};
    last_iter_d = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_m_q     <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      dbz_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (operation == OP_MUL) begin
              mcand_q  <= {{WIDTH{1'b0}}, operand1};
              mplier_q <= operand2;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else if (operation == OP_DIV && operand2 != '0) begin
              rem_q   <= '0;
              quo_q   <= operand1;
              div_m_q <= operand2;
              cnt_q   <= '0;
              state_q <= S_DIV;
            end else begin
              result_q    <= sc_res_d;
              result_hi_q <= sc_hi_d;
              zero_q      <= (sc_res_d == '0);
              carry_q     <= sc_carry_d;
              dbz_q       <= sc_dbz_d;
              ill_q       <= sc_ill_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_iter_d) begin
            result_q    <= acc_d[WIDTH-1:0];
            result_hi_q <= acc_d[2*WIDTH-1:WIDTH];
            zero_q      <= (acc_d[WIDTH-1:0] == '0);
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter_d) begin
            result_q    <= quo_d;
            result_hi_q <= rem_d;
            zero_q      <= (quo_d == '0);
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH = 16): directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic [3:0]   operation;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         out_valid;
  logic         zero;
  logic         carry;
  logic         div_by_zero;
  logic         illegal_op;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .operation(operation),
    .result(result), .result_hi(result_hi), .out_valid(out_valid),
    .zero(zero), .carry(carry), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Reference behaviour straight from the opcode definitions.
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [W-1:0] h,
                       output logic z, output logic c, output logic d, output logic il,
                       output int lat);
    longint unsigned p;
    r = '0; h = '0; c = 1'b0; d = 1'b0; il = 1'b0; lat = 1;
    case (o)
      4'd0: begin r = a + b; c = (int'(a) + int'(b)) > 65535; end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: begin p = longint'(a) * longint'(b); r = p[15:0]; h = p[31:16]; lat = W + 1; end
      4'd3: begin
        if (b == 0) begin r = 16'hFFFF; h = a; d = 1'b1; end
        else begin r = a / b; h = a % b; lat = W + 1; end
      end
      4'd4: r = a << 1;
      4'd5: r = a >> 1;
      4'd6: r = b << 1;
      4'd7: r = b >> 1;
      4'd8: r = a & b;
      4'd9: r = a | b;
      4'd10: r = a ^ b;
      default: il = 1'b1;
    endcase
    z = (r == 0);
  endtask

  // Issue one request, then wait (bounded) for its out_valid pulse.
  // lat counts samples taken #1 after each edge, starting with the accept edge.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output bit rdy_low);
    @(negedge clk);
    operation = o; operand1 = a; operand2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    operand1 = W'($urandom); operand2 = W'($urandom); operation = 4'($urandom);
    lat = 1; rdy_low = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; operand1 = '0; operand2 = '0; operation = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if ({result, result_hi, out_valid, zero, carry, div_by_zero, illegal_op, in_ready} !==
        {32'h0, 5'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got r=%h h=%h ov=%b z=%b c=%b d=%b il=%b rdy=%b want all 0, rdy=1",
               result, result_hi, out_valid, zero, carry, div_by_zero, illegal_op, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   o_t [3] = '{4'd0, 4'd1, 4'd10};
    logic [W-1:0] a_t [3] = '{16'hFFFF, 16'd3, 16'd5};
    logic [W-1:0] b_t [3] = '{16'h0001, 16'd5, 16'd3};
    logic [W-1:0] r_t [3] = '{16'h0000, 16'hFFFE, 16'h0006};
    logic         z_t [3] = '{1'b1, 1'b0, 1'b0};
    logic         c_t [3] = '{1'b1, 1'b1, 1'b0};
    int pulses = 0;
    @(negedge clk);
    in_valid = 1'b1;
    operation = o_t[0]; operand1 = a_t[0]; operand2 = b_t[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
      n_cmp++;
      if ({out_valid, result, zero, carry} !== {1'b1, r_t[i], z_t[i], c_t[i]}) begin
        n_err++;
        $display("FAIL b2b_%0d: got ov=%b r=%h z=%b c=%b want ov=1 r=%h z=%b c=%b",
                 i, out_valid, result, zero, carry, r_t[i], z_t[i], c_t[i]);
      end
      if (i < 2) begin
        operation = o_t[i+1]; operand1 = a_t[i+1]; operand2 = b_t[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    if (out_valid === 1'b1) pulses++;
    n_cmp++;
    if (pulses != 3) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d pulses want 3", pulses);
    end
  endtask

  task automatic test_mul();
    int lat; bit rdy_low;
    run_op(4'd2, 16'hFFFF, 16'hFFFF, lat, rdy_low);
    n_cmp++;
    if (lat != 17 || !rdy_low) begin
      n_err++;
      $display("FAIL mul_timing: got lat=%0d rdy_low=%b want lat=17 rdy_low=1", lat, rdy_low);
    end
    n_cmp++;
    if ({result, result_hi, zero, carry, div_by_zero, illegal_op} !== {16'h0001, 16'hFFFE, 4'b0}) begin
      n_err++;
      $display("FAIL mul_ffff: got r=%h h=%h flags=%b%b%b%b want r=0001 h=fffe flags=0000",
               result, result_hi, zero, carry, div_by_zero, illegal_op);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] a_t [3] = '{16'd7, 16'h8000, 16'd5};
    logic [W-1:0] b_t [3] = '{16'd2, 16'h0003, 16'd9};
    logic [W-1:0] q_t [3] = '{16'd3, 16'h2AAA, 16'd0};
    logic [W-1:0] m_t [3] = '{16'd1, 16'd2, 16'd5};
    logic         z_t [3] = '{1'b0, 1'b0, 1'b1};
    int lat; bit rdy_low;
    for (int i = 0; i < 3; i++) begin
      run_op(4'd3, a_t[i], b_t[i], lat, rdy_low);
      n_cmp++;
      if ({result, result_hi, zero, div_by_zero} !== {q_t[i], m_t[i], z_t[i], 1'b0} || lat != 17) begin
        n_err++;
        $display("FAIL div_%0d: got q=%h r=%h z=%b d=%b lat=%0d want q=%h r=%h z=%b d=0 lat=17",
                 i, result, result_hi, zero, div_by_zero, lat, q_t[i], m_t[i], z_t[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; bit rdy_low;
    run_op(4'd3, 16'd1234, 16'd0, lat, rdy_low);
    n_cmp++;
    if ({result, result_hi, div_by_zero, zero} !== {16'hFFFF, 16'd1234, 1'b1, 1'b0} || lat != 1) begin
      n_err++;
      $display("FAIL div_zero: got q=%h r=%h d=%b z=%b lat=%0d want q=ffff r=04d2 d=1 z=0 lat=1",
               result, result_hi, div_by_zero, zero, lat);
    end
    run_op(4'd4, 16'h8001, 16'h1234, lat, rdy_low);
    n_cmp++;
    if ({result, result_hi, div_by_zero} !== {16'h0002, 16'h0000, 1'b0} || lat != 1) begin
      n_err++;
      $display("FAIL shl_after_dz: got r=%h h=%h d=%b lat=%0d want r=0002 h=0000 d=0 lat=1",
               result, result_hi, div_by_zero, lat);
    end
  endtask

  task automatic test_illegal();
    int lat; bit rdy_low;
    run_op(4'd12, 16'hABCD, 16'h1234, lat, rdy_low);
    n_cmp++;
    if ({result, result_hi, zero, illegal_op, carry, div_by_zero} !== {32'h0, 4'b1100} || lat != 1) begin
      n_err++;
      $display("FAIL illegal_op: got r=%h h=%h z=%b il=%b c=%b d=%b lat=%0d want r=0 h=0 z=1 il=1 lat=1",
               result, result_hi, zero, illegal_op, carry, div_by_zero, lat);
    end
  endtask

  task automatic test_busy_ignore();
    int lat = 1;
    @(negedge clk);
    operation = 4'd2; operand1 = 16'd5; operand2 = 16'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    while (out_valid !== 1'b1 && lat < 100) begin
      operation = 4'd0; operand1 = W'($urandom); operand2 = W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({result, result_hi} !== {16'd15, 16'd0} || lat != 17) begin
      n_err++;
      $display("FAIL busy_ignore: got r=%h h=%h lat=%0d want r=000f h=0000 lat=17", result, result_hi, lat);
    end
  endtask

  task automatic test_reset_mid_div();
    int lat; bit rdy_low; bit saw_ov = 1'b0;
    run_op(4'd0, 16'hFFFF, 16'h0001, lat, rdy_low);
    @(negedge clk);
    operation = 4'd3; operand1 = 16'd100; operand2 = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw_ov = 1'b1;
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_div_ready: got %b want 1", in_ready);
    end
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw_ov = 1'b1;
    end
    n_cmp++;
    if (saw_ov || {result, result_hi, zero, carry, div_by_zero, illegal_op, in_ready} !== {32'h0, 4'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_mid_div: got ov_seen=%b r=%h h=%h z=%b c=%b d=%b il=%b rdy=%b want none, all 0, rdy=1",
               saw_ov, result, result_hi, zero, carry, div_by_zero, illegal_op, in_ready);
    end
  endtask

  task automatic test_random();
    logic [3:0] o; logic [W-1:0] a, b, er, eh; logic ez, ec, ed, ei;
    int elat, lat; bit rdy_low;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : W'($urandom);
      model(o, a, b, er, eh, ez, ec, ed, ei, elat);
      run_op(o, a, b, lat, rdy_low);
      n_cmp++;
      if ({result, result_hi, zero, carry, div_by_zero, illegal_op} !== {er, eh, ez, ec, ed, ei}) begin
        n_err++;
        $display("FAIL rand_%0d op=%0d a=%h b=%h: got r=%h h=%h zcdi=%b%b%b%b want r=%h h=%h zcdi=%b%b%b%b",
                 i, o, a, b, result, result_hi, zero, carry, div_by_zero, illegal_op,
                 er, eh, ez, ec, ed, ei);
      end
      n_cmp++;
      if (lat != elat || !rdy_low) begin
        n_err++;
        $display("FAIL rand_lat_%0d op=%0d: got lat=%0d rdy_low=%b want lat=%0d rdy_low=1",
                 i, o, lat, rdy_low, elat);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || result !== er) begin
        n_err++;
        $display("FAIL rand_hold_%0d: got ov=%b r=%h want ov=0 r=%h", i, out_valid, result, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_div_zero();
    test_illegal();
    test_busy_ignore();
    test_reset_mid_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
